// File: rtl/scarv_soc_mem_defs.sv
// Shared constants for the SoC memory-side blocks.
//   RSP_FIFO_DEPTH : response buffer depth; three entries cover the two-cycle
//                    request-to-response loop plus one slot of slack, which is
//                    what one-per-cycle throughput under backpressure needs.
//   *_W            : request/response field widths.
//   rsp_t          : one response FIFO entry.
package scarv_soc_mem_defs;

    localparam int RSP_FIFO_DEPTH = 3;
    localparam int ERR_W          = 1;
    localparam int ADDR_W         = 32;
    localparam int DATA_W         = 32;
    localparam int STRB_W         = DATA_W / 8;
    localparam int RSP_W          = DATA_W + ERR_W;

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic [ERR_W-1:0]  err;
    } rsp_t;

endpackage

// File: rtl/scarv_soc_rsp_fifo.sv
// Small in-order FIFO with an occupancy output.
// Ports:
//   g_clk, g_resetn : clock, synchronous active-low reset (clears pointers/count)
//   push, push_data : write one entry
//   pop             : drop the head entry
//   head            : current head entry (undefined while count == 0)
//   count           : number of entries held
// Push on full and pop on empty are ignored so the pointers can never slip.
module scarv_soc_rsp_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 3,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             g_clk,
    input  logic             g_resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push & (count != CW'(DEPTH));
    assign do_pop  = pop  & (count != '0);

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge g_clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/scarv_soc_bram_ifc.sv
// Bus-side requester for one port of a dual-port BRAM.
// Accepts valid/ready requests, range-checks them, drives the BRAM port
// combinationally, and returns responses in order through a small FIFO.
// Ports:
//   g_clk, g_resetn           : clock, synchronous active-low reset
//   req_valid/ready           : request handshake
//   req_addr/wen/strb/wdata   : byte address ([1:0] ignored), write flag,
//                               byte enables, write data
//   rsp_valid/ready           : response handshake
//   rsp_rdata, rsp_error      : read data (0 for writes/errors), error flag
//   bram_en/wen/addr/wdata    : BRAM port drive
//   bram_rdata                : BRAM read data, valid the cycle after bram_en
// LW is derived from DEPTH and should not be overridden.
module scarv_soc_bram_ifc
    import scarv_soc_mem_defs::*;
#(
    parameter logic [31:0] BASE     = 32'h0000_0000,
    parameter int          DEPTH    = 1024,
    parameter bit          WRITE_EN = 1'b1,
    parameter int          LW       = $clog2(DEPTH)
) (
    input  logic              g_clk,
    input  logic              g_resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_wen,
    input  logic [STRB_W-1:0] req_strb,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error,
    output logic              bram_en,
    output logic [STRB_W-1:0] bram_wen,
    output logic [LW-1:0]     bram_addr,
    output logic [DATA_W-1:0] bram_wdata,
    input  logic [DATA_W-1:0] bram_rdata
);

    localparam int CW = $clog2(RSP_FIFO_DEPTH + 1);

    logic              acc;
    logic              err;
    logic              ifl_v;
    logic              ifl_err;
    logic              ifl_wen;
    logic [DATA_W-1:0] cap_rdata;
    rsp_t              cap_rsp;
    rsp_t              head;
    logic [CW-1:0]     fifo_count;
    logic              pop;
    logic              unused_addr_lsb;

    // Word-addressed BRAM: the byte lane bits never affect the access.
    assign unused_addr_lsb = ^req_addr[1:0];

    // Counting the in-flight slot as well as the FIFO contents guarantees a
    // FIFO slot for every accepted request, and keeps req_ready free of any
    // combinational path from rsp_ready.
    assign req_ready = g_resetn & ((int'(fifo_count) + int'(ifl_v)) < RSP_FIFO_DEPTH);
    assign acc       = req_valid & req_ready;
    assign err       = (req_addr[ADDR_W-1:LW] != BASE[ADDR_W-1:LW]) | (req_wen & ~WRITE_EN);

    assign bram_en    = acc & ~err;
    assign bram_wen   = (bram_en & req_wen) ? req_strb : '0;
    assign bram_addr  = {req_addr[LW-1:2], 2'b00};
    assign bram_wdata = req_wdata;

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            ifl_v   <= 1'b0;
            ifl_err <= 1'b0;
            ifl_wen <= 1'b0;
        end else begin
            ifl_v   <= acc;
            ifl_err <= err;
            ifl_wen <= req_wen;
        end
    end

    assign cap_rdata     = (ifl_err | ifl_wen) ? '0 : bram_rdata;
    assign cap_rsp.rdata = cap_rdata;
    assign cap_rsp.err   = ifl_err;

    assign rsp_valid = (fifo_count != '0);
    assign pop       = rsp_valid & rsp_ready;

    // Head storage is not reset; gate it so an empty buffer reads as zero.
    assign rsp_rdata = rsp_valid ? head.rdata : '0;
    assign rsp_error = rsp_valid & head.err[0];

    scarv_soc_rsp_fifo #(
        .WIDTH (RSP_W),
        .DEPTH (RSP_FIFO_DEPTH),
        .CW    (CW)
    ) u_rsp_fifo (
        .g_clk     (g_clk),
        .g_resetn  (g_resetn),
        .push      (ifl_v),
        .push_data (cap_rsp),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_scarv_soc_bram_ifc.sv
module tb_scarv_soc_bram_ifc;

    localparam logic [31:0] M_BASE  = 32'h0000_0000;
    localparam int          M_DEPTH = 1024;
    localparam logic [31:0] R_BASE  = 32'h0000_1000;

    logic g_clk = 1'b0;
    logic g_resetn;
    always #5 g_clk = ~g_clk;

    int cyc = 0;
    always @(posedge g_clk) cyc <= cyc + 1;

    // main instance: read/write, base 0
    logic        req_valid, req_ready, req_wen;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_strb;
    logic        rsp_valid, rsp_ready, rsp_error;
    logic [31:0] rsp_rdata;
    logic        bram_en;
    logic [3:0]  bram_wen;
    logic [9:0]  bram_addr;
    logic [31:0] bram_wdata, bram_rdata;

    // second instance: read-only, base 0x1000
    logic        ro_req_valid, ro_req_ready, ro_req_wen;
    logic [31:0] ro_req_addr, ro_req_wdata;
    logic [3:0]  ro_req_strb;
    logic        ro_rsp_valid, ro_rsp_error;
    logic        ro_rsp_ready;
    logic [31:0] ro_rsp_rdata;
    logic        ro_bram_en;
    logic [3:0]  ro_bram_wen;
    logic [9:0]  ro_bram_addr;
    logic [31:0] ro_bram_wdata, ro_bram_rdata;

    scarv_soc_bram_ifc #(.BASE(M_BASE), .DEPTH(M_DEPTH), .WRITE_EN(1'b1)) u_dut (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wen(req_wen), .req_strb(req_strb), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error), .bram_en(bram_en), .bram_wen(bram_wen),
        .bram_addr(bram_addr), .bram_wdata(bram_wdata), .bram_rdata(bram_rdata)
    );

    scarv_soc_bram_ifc #(.BASE(R_BASE), .DEPTH(M_DEPTH), .WRITE_EN(1'b0)) u_ro (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .req_valid(ro_req_valid), .req_ready(ro_req_ready), .req_addr(ro_req_addr),
        .req_wen(ro_req_wen), .req_strb(ro_req_strb), .req_wdata(ro_req_wdata),
        .rsp_valid(ro_rsp_valid), .rsp_ready(ro_rsp_ready), .rsp_rdata(ro_rsp_rdata),
        .rsp_error(ro_rsp_error), .bram_en(ro_bram_en), .bram_wen(ro_bram_wen),
        .bram_addr(ro_bram_addr), .bram_wdata(ro_bram_wdata), .bram_rdata(ro_bram_rdata)
    );

    function automatic logic [31:0] init_val(input int i);
        return 32'(i + 1) * 32'h9E37_79B9;
    endfunction

    // BRAM behavioural models (read-first, one-cycle read latency)
    logic [31:0] mem_a [256];
    logic        mem_a_init = 1'b0;
    always @(posedge g_clk) begin
        if (!mem_a_init) begin
            for (int i = 0; i < 256; i++) mem_a[i] <= init_val(i);
            mem_a_init <= 1'b1;
        end else if (bram_en) begin
            bram_rdata <= mem_a[bram_addr[9:2]];
            for (int b = 0; b < 4; b++)
                if (bram_wen[b]) mem_a[bram_addr[9:2]][8*b +: 8] <= bram_wdata[8*b +: 8];
        end
    end

    logic [31:0] mem_r [256];
    logic        mem_r_init = 1'b0;
    always @(posedge g_clk) begin
        if (!mem_r_init) begin
            for (int i = 0; i < 256; i++) mem_r[i] <= init_val(i);
            mem_r_init <= 1'b1;
        end else if (ro_bram_en) begin
            ro_bram_rdata <= mem_r[ro_bram_addr[9:2]];
            for (int b = 0; b < 4; b++)
                if (ro_bram_wen[b]) mem_r[ro_bram_addr[9:2]][8*b +: 8] <= ro_bram_wdata[8*b +: 8];
        end
    end

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // transaction-level reference model for the main instance
    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    int          rsp_cyc[$];
    logic [31:0] ref_mem [256];
    logic        ref_init = 1'b0;
    int          n_rsp = 0;
    int          n_acc = 0;
    logic [31:0] last_rdata;
    logic        last_err;
    logic        hold_v = 1'b0;
    logic [31:0] hold_d;
    logic        rand_rr = 1'b0;

    always @(negedge g_clk) begin
        exp_t e;
        logic m_err;
        int   idx;
        if (!g_resetn) begin
            if (!ref_init) begin
                for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
                ref_init = 1'b1;
            end
            exp_q.delete();
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("rsp_hold_valid", 32'(rsp_valid), 32'd1);
                chk("rsp_hold_data", rsp_rdata, hold_d);
            end
            hold_v = rsp_valid && !rsp_ready;
            hold_d = rsp_rdata;
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_spurious", 32'(rsp_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_error", 32'(rsp_error), 32'(e.err));
                    last_rdata = rsp_rdata;
                    last_err   = rsp_error;
                    n_rsp++;
                    rsp_cyc.push_back(cyc);
                end
            end
            if (req_valid) begin
                m_err = (req_addr < M_BASE) || (req_addr >= M_BASE + M_DEPTH);
                chk("bram_en", 32'(bram_en), 32'(req_ready && !m_err));
                if (req_ready) begin
                    n_acc++;
                    e.err   = m_err;
                    e.rdata = 32'd0;
                    if (!m_err) begin
                        idx = int'((req_addr - M_BASE) / 4);
                        if (req_wen) begin
                            for (int b = 0; b < 4; b++)
                                if (req_strb[b]) ref_mem[idx][8*b +: 8] = req_wdata[8*b +: 8];
                        end else begin
                            e.rdata = ref_mem[idx];
                        end
                    end
                    exp_q.push_back(e);
                end
            end
        end
    end

    // Present one request and hold it until accepted; returns at posedge+1.
    task automatic send(input logic [31:0] a, input logic w, input logic [3:0] s,
                        input logic [31:0] d, output int stalls);
        logic done;
        req_valid = 1'b1;
        req_addr  = a;
        req_wen   = w;
        req_strb  = s;
        req_wdata = d;
        stalls    = 0;
        done      = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge g_clk);
            if (req_ready) done = 1'b1;
            else stalls++;
            @(posedge g_clk);
            #1;
            if (rand_rr) rsp_ready = ($urandom_range(0, 2) != 0);
        end
        chk("req_accept", 32'(done), 32'd1);
    endtask

    task automatic idle();
        req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(negedge g_clk);
        chk("drain", 32'(exp_q.size()), 32'd0);
        @(posedge g_clk);
        #1;
    endtask

    task automatic ro_txn(input logic [31:0] a, input logic w, input logic [31:0] d,
                          input logic en_exp, input logic [31:0] rd_exp, input logic err_exp);
        ro_req_valid = 1'b1;
        ro_req_addr  = a;
        ro_req_wen   = w;
        ro_req_strb  = 4'hF;
        ro_req_wdata = d;
        @(negedge g_clk);
        chk("ro_req_ready", 32'(ro_req_ready), 32'd1);
        chk("ro_bram_en", 32'(ro_bram_en), 32'(en_exp));
        chk("ro_bram_wen", 32'(ro_bram_wen), 32'd0);
        @(posedge g_clk);
        #1;
        ro_req_valid = 1'b0;
        @(negedge g_clk);
        @(negedge g_clk);
        chk("ro_rsp_valid", 32'(ro_rsp_valid), 32'd1);
        chk("ro_rsp_rdata", ro_rsp_rdata, rd_exp);
        chk("ro_rsp_error", 32'(ro_rsp_error), 32'(err_exp));
        @(posedge g_clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int          st;
        int          tot_st;
        int          k;
        int          n0;
        int          ns;
        logic [5:0]  ready_bits;
        logic [31:0] bp_vals [5];
        logic [31:0] a;

        g_resetn     = 1'b0;
        req_valid    = 1'b0;
        req_addr     = '0;
        req_wen      = 1'b0;
        req_strb     = '0;
        req_wdata    = '0;
        rsp_ready    = 1'b0;
        ro_req_valid = 1'b0;
        ro_req_addr  = '0;
        ro_req_wen   = 1'b0;
        ro_req_strb  = '0;
        ro_req_wdata = '0;
        ro_rsp_ready = 1'b1;

        repeat (3) @(posedge g_clk);
        #1;
        @(negedge g_clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_error", 32'(rsp_error), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        @(posedge g_clk);
        #1;
        g_resetn  = 1'b1;
        rsp_ready = 1'b1;
        @(negedge g_clk);
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        @(posedge g_clk);
        #1;

        // write then read with latency check
        send(32'h10, 1'b1, 4'hF, 32'hDEAD_BEEF, st);
        idle();
        drain();
        chk("wr_ack_rdata", last_rdata, 32'd0);
        chk("wr_ack_err", 32'(last_err), 32'd0);
        send(32'h10, 1'b0, 4'h0, 32'd0, st);
        idle();
        @(negedge g_clk);
        chk("lat_n1_valid", 32'(rsp_valid), 32'd0);
        @(negedge g_clk);
        chk("lat_n2_valid", 32'(rsp_valid), 32'd1);
        chk("lat_n2_rdata", rsp_rdata, 32'hDEAD_BEEF);
        drain();

        // byte strobe
        send(32'h10, 1'b1, 4'h1, 32'h0000_00AA, st);
        send(32'h10, 1'b0, 4'h0, 32'd0, st);
        idle();
        drain();
        chk("strb_read", last_rdata, 32'hDEAD_BEAA);

        // zero-strobe write is acknowledged and changes nothing
        send(32'h12, 1'b1, 4'h0, 32'h1234_5678, st);
        idle();
        drain();
        chk("zstrb_ack_err", 32'(last_err), 32'd0);
        send(32'h10, 1'b0, 4'h0, 32'd0, st);
        idle();
        drain();
        chk("zstrb_read", last_rdata, 32'hDEAD_BEAA);

        // out of range read
        send(32'h400, 1'b0, 4'h0, 32'd0, st);
        idle();
        drain();
        chk("oor_err", 32'(last_err), 32'd1);
        chk("oor_rdata", last_rdata, 32'd0);

        // backpressure
        for (int i = 0; i < 5; i++) begin
            bp_vals[i] = $urandom();
            send(32'h40 + 32'(4 * i), 1'b1, 4'hF, bp_vals[i], st);
        end
        idle();
        drain();
        n0         = n_rsp;
        rsp_ready  = 1'b0;
        k          = 0;
        ready_bits = '0;
        for (int c = 0; c < 6; c++) begin
            req_valid = 1'b1;
            req_addr  = 32'h40 + 32'(4 * k);
            req_wen   = 1'b0;
            req_strb  = 4'h0;
            @(negedge g_clk);
            ready_bits[c] = req_ready;
            if (req_ready) k++;
            @(posedge g_clk);
            #1;
        end
        chk("bp_accepted", 32'(k), 32'd3);
        chk("bp_ready_pattern", 32'(ready_bits), 32'b000111);
        rsp_ready = 1'b1;
        while (k < 5) begin
            send(32'h40 + 32'(4 * k), 1'b0, 4'h0, 32'd0, st);
            k++;
        end
        idle();
        drain();
        chk("bp_rsp_count", 32'(n_rsp - n0), 32'd5);
        chk("bp_last_data", last_rdata, bp_vals[4]);

        // throughput
        tot_st = 0;
        for (int i = 0; i < 16; i++) begin
            a = {22'd0, 8'($urandom()), 2'd0};
            send(a, 1'b0, 4'h0, 32'd0, st);
            tot_st += st;
        end
        idle();
        drain();
        chk("tput_stalls", 32'(tot_st), 32'd0);
        ns = rsp_cyc.size();
        chk("tput_consecutive", 32'(rsp_cyc[ns-1] - rsp_cyc[ns-16]), 32'd15);

        // randomized mix with random backpressure
        rand_rr = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                idle();
                @(posedge g_clk);
                #1;
                rsp_ready = ($urandom_range(0, 2) != 0);
            end else begin
                if ($urandom_range(0, 9) == 0) a = $urandom();
                else a = {22'd0, 8'($urandom()), 2'($urandom())};
                send(a, ($urandom_range(0, 2) == 0), 4'($urandom()), $urandom(), st);
            end
        end
        idle();
        rand_rr   = 1'b0;
        rsp_ready = 1'b1;
        drain();

        // reset with two responses buffered
        rsp_ready = 1'b0;
        send(32'h10, 1'b0, 4'h0, 32'd0, st);
        send(32'h44, 1'b0, 4'h0, 32'd0, st);
        idle();
        @(posedge g_clk);
        #1;
        @(negedge g_clk);
        chk("mid_buffered", 32'(rsp_valid), 32'd1);
        @(posedge g_clk);
        #1;
        g_resetn = 1'b0;
        @(posedge g_clk);
        #1;
        g_resetn = 1'b1;
        @(negedge g_clk);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
        @(posedge g_clk);
        #1;
        rsp_ready = 1'b1;
        n0 = n_rsp;
        send(32'h10, 1'b0, 4'h0, 32'd0, st);
        idle();
        drain();
        repeat (4) @(posedge g_clk);
        #1;
        chk("mid_rst_rsp_count", 32'(n_rsp - n0), 32'd1);
        chk("mid_rst_read", last_rdata, ref_mem[4]);

        // read-only instance
        ro_txn(R_BASE, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'd0, 1'b1);
        ro_txn(R_BASE, 1'b0, 32'd0, 1'b1, init_val(0), 1'b0);
        ro_txn(R_BASE + 32'h3FC, 1'b0, 32'd0, 1'b1, init_val(255), 1'b0);
        ro_txn(32'h0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
